nvram_copier: RTL
=================

NVRAM_COPIER -- requirements
Module: nvram_copier

Interface
REQ-001 Parameter AW, default 8, SHALL set the address width (copy length 2**AW bytes).
REQ-002 Parameter DW, default 8, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all logic on posedge clk.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 store  input  1  SHALL request a working-RAM to backing-RAM copy when high in IDLE.
REQ-006 recall  input  1  SHALL request a backing-RAM to working-RAM copy when high in IDLE.
REQ-007 busy  output  1  SHALL be high while a copy is in progress.
REQ-008 done  output  1  SHALL pulse high for 1 cycle at copy completion.
REQ-009 cpu_a, cpu_d, cpu_r, cpu_w  input  AW, DW, 1, 1  SHALL carry CPU working-RAM address, write data, read strobe and write strobe.
REQ-010 ram_a, ram_i, ram_r, ram_w  output  AW, DW, 1, 1  SHALL drive the working-RAM port.
REQ-011 ram_o  input  DW  SHALL return working-RAM read data, valid the cycle after ram_r.
REQ-012 nv_a, nv_i, nv_r, nv_w  output  AW, DW, 1, 1  SHALL drive the backing-RAM port.
REQ-013 nv_o  input  DW  SHALL return backing-RAM read data, valid the cycle after nv_r.

Function
REQ-014 States SHALL be IDLE, RD, WR, DONE; a 1-bit direction register SHALL record STORE or RECALL.
REQ-015 IDLE: ram_a/ram_i/ram_r/ram_w SHALL combinationally follow cpu_a/cpu_d/cpu_r/cpu_w; nv_r=nv_w=0; busy=0.
REQ-016 IDLE with recall=1 SHALL latch RECALL, clear address counter to 0, go to RD next cycle; recall SHALL win if store and recall are both high.
REQ-017 IDLE with store=1, recall=0 SHALL latch STORE, clear counter, go to RD.
REQ-018 RD: source port read strobe=1 at address=counter, destination strobes 0; next state WR.
REQ-019 WR: destination write strobe=1 at address=counter, destination data = source port output (ram_o for STORE, nv_o for RECALL); source read strobe 0.
REQ-020 WR with counter != all-ones SHALL increment counter and return to RD; with counter = all-ones SHALL go to DONE with counter wrapping to 0.
REQ-021 DONE: done=1 for exactly that cycle, no strobes, next state IDLE.
REQ-022 busy SHALL be high in RD, WR and DONE.
REQ-023 Copy latency SHALL be 2*2**AW + 1 cycles from first RD to DONE inclusive (513 for AW=8); one byte per 2 cycles.
REQ-024 While busy, cpu_r and cpu_w SHALL be ignored; ram_* driven only by the copier.
REQ-025 store/recall while busy SHALL be ignored, not queued.
REQ-026 Level-held store/recall SHALL start a new copy on the IDLE cycle after DONE.
REQ-027 At most one write strobe (ram_w or nv_w) SHALL be high in any cycle.
REQ-028 ram_w and nv_w SHALL never both be high with ram_r or nv_r in the same copy cycle.

Reset
REQ-029 reset_n low SHALL immediately force state IDLE, counter 0, direction STORE, busy=0, done=0, nv_r=nv_w=0.
REQ-030 Reset mid-copy SHALL abort: no further writes; already-copied bytes stay, rest untouched.
REQ-031 After reset_n rises, the block SHALL stay IDLE until a store or recall is sampled.

Verification
REQ-032 Recall: backing RAM[k]=k^8'hA5, 1-cycle recall pulse -> busy high 513 cycles, done pulse once, working RAM[k]=k^8'hA5 for all 256 k.
REQ-033 Store: working RAM[k]=255-k, store pulse -> backing RAM[k]=255-k; no ram_w asserted during copy.
REQ-034 store and recall high same cycle -> RECALL executes (backing contents appear in working RAM).
REQ-035 CPU write cpu_w=1, cpu_a=8'h10, cpu_d=8'h3C during busy -> working RAM[8'h10] holds copied value, not 8'h3C; same write in IDLE -> 8'h3C.
REQ-036 reset_n low after 100 busy cycles -> busy=0, done never pulses, working RAM[0..49] copied, [50..255] unchanged.
REQ-037 Second store pulse at cycle 10 of a recall -> ignored; exactly one done pulse, no store follows.

Source files
------------

// File: rtl/nvram_copier.sv
// Bulk copier between a working RAM and its backing (non-volatile) RAM.
// Copies all 2**AW locations one word per two cycles in either direction.
module nvram_copier #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          store,
  input  logic          recall,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  input  logic          cpu_r,
  input  logic          cpu_w,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_i,
  output logic          ram_r,
  output logic          ram_w,
  input  logic [DW-1:0] ram_o,
  output logic [AW-1:0] nv_a,
  output logic [DW-1:0] nv_i,
  output logic          nv_r,
  output logic          nv_w,
  input  logic [DW-1:0] nv_o
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;
  typedef enum logic {DirStore = 1'b0, DirRecall = 1'b1} dir_e;

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dir_q   <= DirStore;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; recall has priority over store when both are requested.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (recall) begin
          dir_d   = DirRecall;
          cnt_d   = '0;
          state_d = StRd;
        end else if (store) begin
          dir_d   = DirStore;
          cnt_d   = '0;
          state_d = StRd;
        end
      end
      StRd: state_d = StWr;
      StWr: begin
        // The counter wraps to zero naturally on the final word.
        cnt_d   = cnt_q + AW'(1);
        state_d = (cnt_q == {AW{1'b1}}) ? StDone : StRd;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Port steering: the CPU owns the working RAM only while idle.
  always_comb begin
    ram_a = cnt_q;
    ram_i = '0;
    ram_r = 1'b0;
    ram_w = 1'b0;
    nv_a  = cnt_q;
    nv_i  = '0;
    nv_r  = 1'b0;
    nv_w  = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ram_a = cpu_a;
        ram_i = cpu_d;
        ram_r = cpu_r;
        ram_w = cpu_w;
        busy  = 1'b0;
      end
      StRd: begin
        if (dir_q == DirRecall) nv_r = 1'b1;
        else                    ram_r = 1'b1;
      end
      StWr: begin
        if (dir_q == DirRecall) begin
          ram_w = 1'b1;
          ram_i = nv_o;
        end else begin
          nv_w = 1'b1;
          nv_i = ram_o;
        end
      end
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
